// File: rtl/prf_wr_bank_scheduler.sv
// Banked PRF write scheduler: per-requester input FIFOs feeding one round-robin
// arbiter per bank, with registered bank write outputs that double as writeback broadcast.
module prf_wr_bank_scheduler #(
  parameter int PRF_WR_COUNT             = 8,
  parameter int PRF_BANK_COUNT           = 4,
  parameter int PR_COUNT                 = 128,
  parameter int PRF_WR_INPUT_BUFFER_SIZE = 2,
  parameter int XLEN                     = 64,
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT),
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
  localparam int UPPER_W            = LOG_PR_COUNT - LOG_PRF_BANK_COUNT,
  localparam int SRC_W              = $clog2(PRF_WR_COUNT)
) (
  input  logic                                        CLK,
  input  logic                                        nRST,
  input  logic [PRF_WR_COUNT-1:0]                     req_valid,
  input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]   req_PR,
  input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]           req_data,
  output logic [PRF_WR_COUNT-1:0]                     req_ready,
  output logic [PRF_BANK_COUNT-1:0]                   bank_wr_valid,
  output logic [PRF_BANK_COUNT-1:0][UPPER_W-1:0]      bank_wr_upper_PR,
  output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]         bank_wr_data,
  output logic [PRF_BANK_COUNT-1:0][SRC_W-1:0]        bank_wr_src
);

  localparam int SIZE  = PRF_WR_INPUT_BUFFER_SIZE;
  localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CNT_W = $clog2(SIZE + 1);

  logic [LOG_PR_COUNT-1:0] fifo_pr   [PRF_WR_COUNT][SIZE];
  logic [XLEN-1:0]         fifo_data [PRF_WR_COUNT][SIZE];
  logic [PTR_W-1:0]        head_q    [PRF_WR_COUNT];
  logic [PTR_W-1:0]        tail_q    [PRF_WR_COUNT];
  logic [CNT_W-1:0]        count_q   [PRF_WR_COUNT];
  logic [SRC_W-1:0]        rr_q      [PRF_BANK_COUNT];

  logic [PRF_WR_COUNT-1:0]       head_valid, enq, deq;
  logic [LOG_PR_COUNT-1:0]       head_pr   [PRF_WR_COUNT];
  logic [XLEN-1:0]               head_data [PRF_WR_COUNT];
  logic [PRF_BANK_COUNT-1:0]     grant_valid;
  logic [SRC_W-1:0]              grant_idx   [PRF_BANK_COUNT];
  logic [UPPER_W-1:0]            grant_upper [PRF_BANK_COUNT];
  logic [XLEN-1:0]               grant_data  [PRF_BANK_COUNT];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [SRC_W-1:0] src_inc(input logic [SRC_W-1:0] s);
    return (s == SRC_W'(PRF_WR_COUNT - 1)) ? '0 : s + 1'b1;
  endfunction

  // Ready depends only on start-of-cycle occupancy, so a full FIFO never passes through.
  always_comb begin
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      req_ready[i]  = (count_q[i] != CNT_W'(SIZE));
      enq[i]        = req_valid[i] & req_ready[i];
      head_valid[i] = (count_q[i] != '0);
      head_pr[i]    = fifo_pr[i][head_q[i]];
      head_data[i]  = fifo_data[i][head_q[i]];
    end
  end

  always_comb begin
    deq         = '0;
    grant_valid = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      grant_idx[b]   = '0;
      grant_upper[b] = '0;
      grant_data[b]  = '0;
    end
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int k = 0; k < PRF_WR_COUNT; k++) begin
        int idx;
        idx = int'(rr_q[b]) + k;
        if (idx >= PRF_WR_COUNT) idx = idx - PRF_WR_COUNT;
        if (!grant_valid[b] && head_valid[idx] &&
            head_pr[idx][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b)) begin
          grant_valid[b] = 1'b1;
          grant_idx[b]   = SRC_W'(idx);
          grant_upper[b] = head_pr[idx][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
          grant_data[b]  = head_data[idx];
          deq[idx]       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      if (enq[i]) begin
        fifo_pr[i][tail_q[i]]   <= req_PR[i];
        fifo_data[i][tail_q[i]] <= req_data[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        if (enq[i]) tail_q[i] <= ptr_inc(tail_q[i]);
        if (deq[i]) head_q[i] <= ptr_inc(head_q[i]);
        if (enq[i] && !deq[i])      count_q[i] <= count_q[i] + 1'b1;
        else if (!enq[i] && deq[i]) count_q[i] <= count_q[i] - 1'b1;
      end
    end
  end

  // Idle banks hold their last payload; only the valid bit drops.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bank_wr_valid    <= '0;
      bank_wr_upper_PR <= '0;
      bank_wr_data     <= '0;
      bank_wr_src      <= '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) rr_q[b] <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        bank_wr_valid[b] <= grant_valid[b];
        if (grant_valid[b]) begin
          bank_wr_upper_PR[b] <= grant_upper[b];
          bank_wr_data[b]     <= grant_data[b];
          bank_wr_src[b]      <= grant_idx[b];
          rr_q[b]             <= src_inc(grant_idx[b]);
        end
      end
    end
  end

endmodule
